// File: rtl/status_reg.sv
// rtl/status_reg.sv - 6502/65Org16 processor status (P) register with delayed IRQ mask
//
// Purpose:
//   Holds the C, Z, I, D, V and N flags of the processor status register.
//   These flags are fed by:
//     - the registered ALU flag outputs;
//     - explicit flag instructions;
//     - BIT semantics;
//     - PLP/RTI loads;
//     - interrupt entry.
//   The block also produces the P byte for stack pushes.
//   It also produces irq_mask, the IRQ mask as the interrupt logic sees it.
//   irq_mask follows I one instruction late, with two exceptions: RTI and
//   interrupt entry update it together with I.
//
// Configuration:
//   IRQ_CLEARS_D_EN   when defined, irq_entry also clears D (65C02 behaviour);
//                     otherwise D is left alone (NMOS behaviour).
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   RDY                          1 = advance, 0 = hold every register
//   sync                         opcode fetch strobe (instruction boundary)
//   alu_co/alu_v/alu_z/alu_n     registered ALU flag outputs
//   upd_nz/upd_c/upd_v           capture ALU flags into N,Z / C / V
//   bit_op                       BIT: N,V taken from di[dw-1], di[dw-2]
//   load_p, rti                  PLP/RTI load of flags from di[7:0]
//   irq_entry                    interrupt/BRK entry, sets I
//   set_*/clr_*                  explicit flag instructions
//   brk_push                     B bit value placed in p_push
//   di                           data input bus
//   C,Z,I,D,V,N                  flag outputs
//   p_push                       P byte for pushes, zero-extended to dw
//   irq_mask                     effective IRQ mask

module status_reg #(
  parameter int dw = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          RDY,
  input  logic          sync,
  input  logic          alu_co,
  input  logic          alu_v,
  input  logic          alu_z,
  input  logic          alu_n,
  input  logic          upd_nz,
  input  logic          upd_c,
  input  logic          upd_v,
  input  logic          bit_op,
  input  logic          load_p,
  input  logic          rti,
  input  logic          irq_entry,
  input  logic          set_c,
  input  logic          clr_c,
  input  logic          set_i,
  input  logic          clr_i,
  input  logic          set_d,
  input  logic          clr_d,
  input  logic          clr_v,
  input  logic          brk_push,
  input  logic [dw-1:0] di,
  output logic          C,
  output logic          Z,
  output logic          I,
  output logic          D,
  output logic          V,
  output logic          N,
  output logic [dw-1:0] p_push,
  output logic          irq_mask
);

  logic c_q, c_d;
  logic z_q, z_d;
  logic i_q, i_d;
  logic d_q, d_d;
  logic v_q, v_d;
  logic n_q, n_d;
  logic mask_q, mask_d;

  always_comb begin
    c_d    = c_q;
    z_d    = z_q;
    i_d    = i_q;
    d_d    = d_q;
    v_d    = v_q;
    n_d    = n_q;
    mask_d = mask_q;

    if (RDY) begin
      if (load_p) begin
        // PLP/RTI overrides every other strobe in the cycle.
        c_d = di[0];
        z_d = di[1];
        i_d = di[2];
        d_d = di[3];
        v_d = di[6];
        n_d = di[7];
        if (rti) begin
          mask_d = di[2];
        end else if (sync) begin
          mask_d = i_q;
        end
      end else begin
        if (clr_c) begin
          c_d = 1'b0;
        end else if (set_c) begin
          c_d = 1'b1;
        end else if (upd_c) begin
          c_d = alu_co;
        end

        if (upd_nz) begin
          z_d = alu_z;
        end

        if (bit_op) begin
          n_d = di[dw-1];
        end else if (upd_nz) begin
          n_d = alu_n;
        end

        if (clr_v) begin
          v_d = 1'b0;
        end else if (bit_op) begin
          v_d = di[dw-2];
        end else if (upd_v) begin
          v_d = alu_v;
        end

        if (irq_entry) begin
          i_d = 1'b1;
        end else if (clr_i) begin
          i_d = 1'b0;
        end else if (set_i) begin
          i_d = 1'b1;
        end

`ifdef IRQ_CLEARS_D_EN
        if (irq_entry || clr_d) begin
          d_d = 1'b0;
        end else if (set_d) begin
          d_d = 1'b1;
        end
`else
        if (clr_d) begin
          d_d = 1'b0;
        end else if (set_d) begin
          d_d = 1'b1;
        end
`endif

        // The mask normally trails I by one instruction (sampled at opcode
        // fetch). Interrupt entry masks immediately so that a pending IRQ
        // cannot re-enter.
        if (irq_entry) begin
          mask_d = 1'b1;
        end else if (sync) begin
          mask_d = i_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      i_q    <= 1'b1;
      d_q    <= 1'b0;
      v_q    <= 1'b0;
      n_q    <= 1'b0;
      mask_q <= 1'b1;
    end else begin
      c_q    <= c_d;
      z_q    <= z_d;
      i_q    <= i_d;
      d_q    <= d_d;
      v_q    <= v_d;
      n_q    <= n_d;
      mask_q <= mask_d;
    end
  end

  always_comb begin
    p_push      = '0;
    p_push[7:0] = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
  end

  assign C        = c_q;
  assign Z        = z_q;
  assign I        = i_q;
  assign D        = d_q;
  assign V        = v_q;
  assign N        = n_q;
  assign irq_mask = mask_q;

endmodule
